alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  request; sampled only in IDLE.
REQ-005 SELECT  input  6  op code: 001000 MUL, 001001 MULH, 001010 MULHSU, 001011 MULHU, 001100 DIV, 001101 DIVU, 001110 REM, 001111 REMU.
REQ-006 DATA1  input  32  rs1 operand (dividend/multiplicand).
REQ-007 DATA2  input  32  rs2 operand (divisor/multiplier).
REQ-008 BUSY  output  1  operation in progress; new START ignored.
REQ-009 DONE  output  1  one-cycle pulse; RESULT valid.
REQ-010 RESULT  output  32  registered result; held until next DONE.

Function
REQ-011 States IDLE, CALC, FINISH; IDLE->CALC on accepted START, CALC->FINISH after 32 iterations, FINISH->IDLE unconditionally.
REQ-012 START accepted only in IDLE with SELECT[5:3]=001; any other SELECT ignored, no BUSY, no DONE.
REQ-013 On acceptance: latch SELECT, operand magnitudes and result sign; operands not resampled afterwards.
REQ-014 Multiply: radix-2 shift-add on magnitudes, 64-bit product, one bit per cycle, sign-corrected in FINISH.
REQ-015 MUL returns product[31:0]; MULH signed x signed [63:32]; MULHSU signed DATA1 x unsigned DATA2 [63:32]; MULHU unsigned [63:32].
REQ-016 Divide: restoring, one quotient bit per cycle on magnitudes; quotient sign = sign1 XOR sign2, remainder sign = dividend sign (signed ops only).
REQ-017 Normal latency: START accepted at edge 0, DONE=1 and RESULT valid in the cycle after edge 33; BUSY high from edge 0 until DONE rises.
REQ-018 Divide by zero: fast path, FINISH entered directly; DONE in cycle after edge 1; DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> DATA1.
REQ-019 Signed overflow (DIV/REM, DATA1=0x80000000, DATA2=0xFFFFFFFF): fast path, latency 1; DIV -> 0x80000000, REM -> 0.
REQ-020 START asserted while BUSY or during DONE cycle is ignored, not queued.
REQ-021 DONE never asserts for two consecutive cycles; BUSY and DONE never both high.

Reset
REQ-022 RESET_N low: state IDLE, BUSY=0, DONE=0, RESULT=0, counter and datapath registers cleared, asynchronously.
REQ-023 Reset during CALC aborts operation; no DONE afterwards; first START after release behaves normally.

Configuration
REQ-024 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit multiplier, go IDLE->FINISH, DONE in cycle after edge 1; divide unchanged.
REQ-025 Macro undefined: all multiplies iterative per REQ-014/REQ-017; no combinational 32x32 multiplier synthesized.

Structure
REQ-026 Package muldiv_pkg holds SELECT op constants, state encoding and ITER_COUNT=32.
REQ-027 Sub-module muldiv_div_core holds restoring-divide iteration (remainder/quotient registers, step enable); FSM, sign fix-up and multiply stay in top.

Verification
REQ-028 MUL DATA1=0x00007E00, DATA2=0xB6DB6DB7 -> RESULT=0x00001200, DONE 33 cycles after START.
REQ-029 MULHSU 0x80000000, 0xFFFF8000 -> 0x80004000; MULHU same operands -> 0x7FFFC000; MULH 0xFFFFFFFF, 0xFFFFFFFF -> 0x00000000.
REQ-030 DIV 0x00000007/0 -> 0xFFFFFFFF and REM 7/0 -> 0x00000007, each DONE 1 cycle after START.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, latency 1; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-032 START pulsed with DIVU 9/2 at cycle 5 of a MUL -> single DONE with MUL result, DIVU never executed.
REQ-033 RESET_N low at cycle 10 of DIVU -> BUSY=0, RESULT=0 immediately, no DONE; next DIVU 3/2 -> 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the sequential multiply/divide unit:
//   - SELECT op codes (the 001xxx group of the ALU op space)
//   - FSM state encoding
//   - ITER_COUNT, the number of one-bit iterations per operation
//   - op_is_div helper, true for the four divide/remainder codes
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [2:0] OP_GROUP = 3'b001;

    localparam logic [5:0] OP_MUL    = 6'b001000;
    localparam logic [5:0] OP_MULH   = 6'b001001;
    localparam logic [5:0] OP_MULHSU = 6'b001010;
    localparam logic [5:0] OP_MULHU  = 6'b001011;
    localparam logic [5:0] OP_DIV    = 6'b001100;
    localparam logic [5:0] OP_DIVU   = 6'b001101;
    localparam logic [5:0] OP_REM    = 6'b001110;
    localparam logic [5:0] OP_REMU   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Bit 2 of the op code separates the divide half from the multiply half.
    function automatic logic op_is_div(input logic [5:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load                 capture dividend/divisor and clear the remainder
//   step                 perform one restoring iteration
//   dividend, divisor    unsigned magnitudes, sampled only on load
//   quotient, remainder  unsigned results, valid after XLEN steps
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] divisor_q;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] trial;
    logic            fits;

    // The quotient register doubles as the dividend shift register: its top
    // bit moves into the partial remainder while the new quotient bit enters
    // from the bottom.
    assign shifted = {remainder, quotient[XLEN-1]};
    assign fits    = shifted >= {1'b0, divisor_q};
    // When the divisor fits, the true difference is below the divisor and so
    // always fits in XLEN bits; the dropped carry is never significant.
    assign trial   = shifted[XLEN-1:0] - divisor_q;

    // Remainder/quotient iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            divisor_q <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (step) begin
            quotient  <= {quotient[XLEN-2:0], fits};
            remainder <= fits ? trial : shifted[XLEN-1:0];
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Sequential RISC-V style M-extension unit: MUL/MULH/MULHSU/MULHU by
// radix-2 shift-add, DIV/DIVU/REM/REMU by restoring division, both on
// operand magnitudes with the sign applied in the FINISH state.
// Divide by zero and signed overflow take a one-cycle fast path.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, sampled only in IDLE outside the DONE cycle
//   select[5:0]    op code (001xxx group); other codes are ignored
//   data1, data2   rs1 / rs2 operands, latched on acceptance
//   busy           operation in progress
//   done           one-cycle pulse, result valid
//   result         registered result, held until the next done
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, multiplies use a single-cycle 64-bit
//                       multiplier and go straight to FINISH.
module alu_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      select,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [5:0]        op;
    logic [5:0]        count;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic              neg_res;
    logic              neg_rem;
    logic              special;
    logic [XLEN-1:0]   special_result;

    logic              in_signed1;
    logic              in_signed2;
    logic              in_neg1;
    logic              in_neg2;
    logic              in_is_div;
    logic              in_div_zero;
    logic              in_overflow;
    logic              accept;
    logic [XLEN-1:0]   in_mag1;
    logic [XLEN-1:0]   in_mag2;

    logic              div_load;
    logic              div_step;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // Operand decode on the incoming request. MUL is treated as unsigned
    // because the low half of the product does not depend on signedness.
    assign in_signed1  = (select == OP_MULH) || (select == OP_MULHSU) ||
                         (select == OP_DIV)  || (select == OP_REM);
    assign in_signed2  = (select == OP_MULH) || (select == OP_DIV) ||
                         (select == OP_REM);
    assign in_neg1     = in_signed1 & data1[XLEN-1];
    assign in_neg2     = in_signed2 & data2[XLEN-1];
    assign in_mag1     = in_neg1 ? -data1 : data1;
    assign in_mag2     = in_neg2 ? -data2 : data2;
    assign in_is_div   = op_is_div(select);
    assign in_div_zero = in_is_div && (data2 == '0);
    assign in_overflow = ((select == OP_DIV) || (select == OP_REM)) &&
                         (data1 == MIN_NEG) && (data2 == '1);

    // A request landing in the DONE cycle is dropped so done can never
    // pulse twice in a row.
    assign accept = (state == ST_IDLE) && start && !done &&
                    (select[5:3] == OP_GROUP);

    assign div_load = accept && in_is_div;
    assign div_step = (state == ST_CALC) && op_is_div(op);

    muldiv_div_core #(
        .XLEN(XLEN)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (in_mag1),
        .divisor   (in_mag2),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Shift-add step: the multiplier sits in the low half of prod and is
    // consumed LSB first while the partial product grows into the high half.
    assign mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} +
                     (prod[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});

    assign prod_fix = neg_res ? -prod : prod;
    assign quot_fix = neg_res ? -quotient : quotient;
    assign rem_fix  = neg_rem ? -remainder : remainder;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(in_mag1) * (2*XLEN)'(in_mag2);
`endif

    // Control FSM together with the multiply datapath and the registered
    // outputs; busy drops in the same edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            op             <= '0;
            count          <= '0;
            mcand          <= '0;
            prod           <= '0;
            neg_res        <= 1'b0;
            neg_rem        <= 1'b0;
            special        <= 1'b0;
            special_result <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op      <= select;
                        mcand   <= in_mag1;
                        prod    <= {{XLEN{1'b0}}, in_mag2};
                        count   <= '0;
                        busy    <= 1'b1;
                        neg_res <= in_neg1 ^ in_neg2;
                        neg_rem <= in_neg1;
                        special <= in_div_zero || in_overflow;
                        if (in_div_zero) begin
                            special_result <= ((select == OP_DIV) || (select == OP_DIVU)) ?
                                              '1 : data1;
                        end else begin
                            special_result <= (select == OP_DIV) ? MIN_NEG : '0;
                        end
                        if (in_div_zero || in_overflow) begin
                            state <= ST_FINISH;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!in_is_div) begin
                            prod  <= fast_prod;
                            state <= ST_FINISH;
`endif
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (!op_is_div(op)) begin
                        prod <= {mul_sum, prod[XLEN-1:1]};
                    end
                    if (count == 6'(ITER_COUNT - 1)) begin
                        state <= ST_FINISH;
                    end
                    count <= count + 6'd1;
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (special) begin
                        result <= special_result;
                    end else begin
                        case (op)
                            OP_MULH, OP_MULHSU, OP_MULHU: result <= prod_fix[2*XLEN-1:XLEN];
                            OP_DIV, OP_DIVU:              result <= quot_fix;
                            OP_REM, OP_REMU:              result <= rem_fix;
                            default:                      result <= prod_fix[XLEN-1:0];
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq
// Self-checking bench for alu_muldiv_seq. A cycle-level reference model
// built from plain 64-bit arithmetic and a remaining-cycles counter predicts
// busy/done/result every cycle; directed vectors with hand-computed values
// pin the model and the latencies.
module tb_alu_muldiv_seq;

    localparam logic [5:0] T_MUL    = 6'b001000;
    localparam logic [5:0] T_MULH   = 6'b001001;
    localparam logic [5:0] T_MULHSU = 6'b001010;
    localparam logic [5:0] T_MULHU  = 6'b001011;
    localparam logic [5:0] T_DIV    = 6'b001100;
    localparam logic [5:0] T_DIVU   = 6'b001101;
    localparam logic [5:0] T_REM    = 6'b001110;
    localparam logic [5:0] T_REMU   = 6'b001111;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  select;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int check_count = 0;
    int pass_count  = 0;

    logic        m_busy;
    logic        m_done;
    logic [31:0] m_result;
    logic [31:0] m_pending;
    int          m_remaining;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .select (select),
        .data1  (data1),
        .data2  (data2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference result from the arithmetic definition of each op.
    function automatic logic [31:0] model_result(input logic [5:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            T_MUL:    begin p = ua * ub;           return p[31:0];  end
            T_MULH:   begin p = sa * sb;           return p[63:32]; end
            T_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            T_MULHU:  begin p = ua * ub;           return p[63:32]; end
            T_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            T_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            T_REM: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Edges from acceptance to the edge that raises done.
    function automatic int model_latency(input logic [5:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((op == T_DIV || op == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Cycle model: a request is taken only when nothing is pending and no
    // done pulse is showing; the answer appears after its latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy      <= 1'b0;
            m_done      <= 1'b0;
            m_result    <= 32'h0;
            m_pending   <= 32'h0;
            m_remaining <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_remaining != 0) begin
                m_remaining <= m_remaining - 1;
                if (m_remaining == 1) begin
                    m_done   <= 1'b1;
                    m_busy   <= 1'b0;
                    m_result <= m_pending;
                end
            end else if (start && !m_done && select[5:3] == 3'b001) begin
                m_pending   <= model_result(select, data1, data2);
                m_remaining <= model_latency(select, data1, data2);
                m_busy      <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            check_count++;
            if (busy === m_busy && done === m_done && result === m_result) begin
                pass_count++;
            end else begin
                $display("[TB] FAIL cycle_compare t=%0t busy %b/%b done %b/%b result %h/%h (actual/required)",
                         $time, busy, m_busy, done, m_done, result, m_result);
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
        check_count++;
        if (actual === required) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, required);
        end
    endtask

    // Drives one start pulse; returns 2 time units after the sampling edge.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(posedge clk);
        #2;
        start  = 1'b1;
        select = op;
        data1  = a;
        data2  = b;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    // Waits (bounded) for done and checks result and latency in edges.
    task automatic checkOutput(input string name, input logic [31:0] exp_res,
                               input int exp_lat, input int already);
        int n;
        n = already;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        if (done !== 1'b1) begin
            check_count++;
            $display("[TB] FAIL %s_timeout: no done after %0d cycles, required done", name, n);
        end else begin
            checkValue({name, "_result"}, result, exp_res);
            checkValue({name, "_latency"}, n, exp_lat);
        end
    endtask

    // Expects no done pulse and no busy for a number of cycles.
    task automatic expectQuiet(input string name, input int cycles);
        int dones;
        int busys;
        dones = 0;
        busys = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (busy) busys++;
        end
        checkValue({name, "_done_cycles"}, dones, 0);
        checkValue({name, "_busy_cycles"}, busys, 0);
    endtask

    task automatic runVector(input string name, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input int exp_lat);
        checkValue({name, "_model"}, model_result(op, a, b), exp_res);
        applyStimulus(op, a, b);
        checkOutput(name, exp_res, exp_lat, 0);
    endtask

    initial begin
        logic [31:0] long_res;
        rst_n  = 1'b1;
        start  = 1'b0;
        select = 6'h0;
        data1  = 32'h0;
        data2  = 32'h0;
        #1 rst_n = 1'b0;
        #10;
        checkValue("reset_busy", {31'd0, busy}, 32'd0);
        checkValue("reset_done", {31'd0, done}, 32'd0);
        checkValue("reset_result", result, 32'h0);
        #11 rst_n = 1'b1;

        runVector("mul_basic",    T_MUL,    32'h0000_7E00, 32'hB6DB_6DB7, 32'h0000_1200, MUL_LAT);
        runVector("mulhsu_min",   T_MULHSU, 32'h8000_0000, 32'hFFFF_8000, 32'h8000_4000, MUL_LAT);
        runVector("mulhu_min",    T_MULHU,  32'h8000_0000, 32'hFFFF_8000, 32'h7FFF_C000, MUL_LAT);
        runVector("mulh_neg1",    T_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        runVector("div_by_zero",  T_DIV,    32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        runVector("rem_by_zero",  T_REM,    32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1);
        runVector("remu_by_zero", T_REMU,   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1);
        runVector("div_ovf",      T_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        runVector("rem_ovf",      T_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        runVector("divu_no_ovf",  T_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        runVector("div_neg",      T_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        runVector("rem_neg",      T_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 16; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = {3'b001, 3'(i)};
            a  = $urandom;
            b  = (i >= 8) ? $urandom_range(1, 300) : $urandom;
            applyStimulus(op, a, b);
            checkOutput($sformatf("model_vec%0d", i), model_result(op, a, b),
                        model_latency(op, a, b), 0);
        end

        applyStimulus(6'b011000, 32'd5, 32'd5);
        expectQuiet("foreign_op", 6);
        applyStimulus(6'b000000, 32'd5, 32'd5);
        expectQuiet("zero_op", 6);

        // A second request arrives five edges into a long operation.
`ifdef MULDIV_FAST_MUL_EN
        applyStimulus(T_DIVU, 32'd100, 32'd7);
        long_res = 32'd14;
`else
        applyStimulus(T_MUL, 32'h0000_7E00, 32'hB6DB_6DB7);
        long_res = 32'h0000_1200;
`endif
        repeat (4) @(posedge clk);
        #2;
        start  = 1'b1;
        select = T_DIVU;
        data1  = 32'd9;
        data2  = 32'd2;
        @(posedge clk);
        #2;
        start = 1'b0;
        checkOutput("start_while_busy", long_res, 33, 5);
        // A request held only during the done cycle must be dropped.
        start  = 1'b1;
        select = T_DIVU;
        data1  = 32'd9;
        data2  = 32'd2;
        @(posedge clk);
        #2;
        start = 1'b0;
        expectQuiet("start_in_done_cycle", 45);

        // Reset in the middle of a divide.
        applyStimulus(T_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("abort_busy", {31'd0, busy}, 32'd0);
        checkValue("abort_done", {31'd0, done}, 32'd0);
        checkValue("abort_result", result, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        expectQuiet("after_abort", 45);
        runVector("divu_after_reset", T_DIVU, 32'd3, 32'd2, 32'd1, 33);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
